// File: rtl/frame_pkg.sv
// Shared framing constants and state types for the image-frame transmit path.
// The receive-side SOF/EOF tracker imports the same SOF/EOF byte values.
package frame_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h5A;
    localparam logic [7:0] EOF_BYTE = 8'hA5;
    localparam logic [7:0] ESC_A5   = 8'hA4;
    localparam logic [7:0] ESC_5A   = 8'h5B;

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        PAY,
        EOF,
        FIN
    } frame_state_t;

    typedef enum logic [1:0] {
        ISS_IDLE,
        ISS_WAIT_HI,
        ISS_WAIT_LO
    } issue_state_t;

    // Replaces payload bytes that would look like a frame marker to the receiver.
    function automatic logic [7:0] escape_byte(input logic [7:0] b, input logic en);
        logic [7:0] r;
        r = b;
        if (en) begin
            if (b == EOF_BYTE) begin
                r = ESC_A5;
            end else if (b == SOF_BYTE) begin
                r = ESC_5A;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_byte_issue.sv
// Per-byte handshake with the UART TX core: launch with a tx_start pulse, then
// follow tx_busy high and low, giving up on the rise after BUSY_TIMEOUT cycles.
module uart_byte_issue
    import frame_pkg::*;
#(
    parameter logic [15:0] BUSY_TIMEOUT = 16'd64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send,
    input  logic [7:0] byte_in,
    output logic       idle,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy
);

    issue_state_t state;
    issue_state_t state_next;
    logic [15:0]  timer;
    logic         launch;
    logic         timed_out;

    // A launch is refused while the UART still shifts, e.g. after a reset mid-byte.
    assign idle      = (state == ISS_IDLE) && !tx_busy;
    assign launch    = send && idle;
    assign timed_out = ({1'b0, timer} + 17'd1) >= {1'b0, BUSY_TIMEOUT};

    always_comb begin
        state_next = state;
        case (state)
            ISS_IDLE: begin
                if (launch) begin
                    state_next = ISS_WAIT_HI;
                end
            end
            ISS_WAIT_HI: begin
                if (tx_busy) begin
                    state_next = ISS_WAIT_LO;
                end else if (timed_out) begin
                    state_next = ISS_IDLE;
                end
            end
            ISS_WAIT_LO: begin
                if (!tx_busy) begin
                    state_next = ISS_IDLE;
                end
            end
            default: state_next = ISS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ISS_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer    <= 16'd0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= launch;
            if (launch) begin
                tx_data <= byte_in;
                timer   <= 16'd0;
            end else if (state == ISS_WAIT_HI) begin
                timer <= timer + 16'd1;
            end
        end
    end

endmodule

// File: rtl/frame_tx.sv
// Transmit framer: SOF 0x5A, PAYLOAD_LEN pixel bytes, EOF 0xA5 into the UART TX core.
// Define FRAME_TX_ESC_EN to remap payload 0xA5/0x5A to 0xA4/0x5B.
module frame_tx
    import frame_pkg::*;
#(
    parameter logic [15:0] PAYLOAD_LEN  = 16'd4096,
    parameter logic [15:0] BUSY_TIMEOUT = 16'd64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        busy,
    output logic        done,
    output logic [15:0] byte_cnt
);

`ifdef FRAME_TX_ESC_EN
    localparam logic ESC_EN = 1'b1;
`else
    localparam logic ESC_EN = 1'b0;
`endif

    frame_state_t state;
    frame_state_t state_next;
    logic         entry;
    logic         launched;
    logic         pend;
    logic [7:0]   hold;
    logic         abort_q;
    logic         send;
    logic [7:0]   send_byte;
    logic         issue_idle;
    logic         accept;
    logic         room;

    assign room   = byte_cnt < PAYLOAD_LEN;
    assign accept = pix_ready && pix_valid;
    assign busy   = (state != IDLE);
    assign done   = (state == FIN);

    // SOF waits out its entry cycle so the first launch lands two cycles after start.
    always_comb begin
        state_next = state;
        send       = 1'b0;
        send_byte  = SOF_BYTE;
        pix_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = SOF;
                end
            end
            SOF: begin
                if (issue_idle && !entry) begin
                    if (!launched) begin
                        send = 1'b1;
                    end else begin
                        state_next = abort_q ? EOF : PAY;
                    end
                end
            end
            PAY: begin
                send_byte = escape_byte(hold, ESC_EN);
                if (issue_idle) begin
                    if (pend) begin
                        send = 1'b1;
                    end else if (!room || abort_q) begin
                        state_next = EOF;
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
            end
            EOF: begin
                send_byte = EOF_BYTE;
                if (issue_idle) begin
                    if (!launched) begin
                        send = 1'b1;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            entry    <= 1'b0;
            launched <= 1'b0;
        end else begin
            state    <= state_next;
            entry    <= (state_next != state);
            launched <= (state_next != state) ? 1'b0 : (launched | send);
        end
    end

    // An accepted pixel is parked in hold until the issuer launches it next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= 16'd0;
            pend     <= 1'b0;
            hold     <= 8'h00;
            abort_q  <= 1'b0;
        end else begin
            if ((state == IDLE) && start) begin
                byte_cnt <= 16'd0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 16'd1;
            end
            if (accept) begin
                pend <= 1'b1;
                hold <= pix_data;
            end else if (send && (state == PAY)) begin
                pend <= 1'b0;
            end
            if (state == IDLE) begin
                abort_q <= 1'b0;
            end else if (((state == SOF) || (state == PAY)) && abort) begin
                abort_q <= 1'b1;
            end
        end
    end

    uart_byte_issue #(
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) u_issue (
        .clk      (clk),
        .rst_n    (rst_n),
        .send     (send),
        .byte_in  (send_byte),
        .idle     (issue_idle),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy)
    );

endmodule
